// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing: counters, syncs, one-clock-early pixel requests and gated RGB.
// Optional feature: define VGA_BORDER_EN to force a white frame border on the active area.
module vga_timing_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10,
  parameter int V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_VALID - 2);

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       frame_start_q, frame_start_d;
  logic       h_end, v_end;
  logic       act_h, act_v, req_h, pix_req;

  always_comb begin
    h_end         = (cnt_h_q == H_LAST);
    v_end         = (cnt_v_q == V_LAST);
    cnt_h_d       = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d       = cnt_v_q;
    if (h_end) begin
      cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
    end
    // The pulse lands on the same edge that wraps both counters back to (0,0).
    frame_start_d = h_end && v_end;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= 10'd0;
      cnt_v_q       <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Requests lead the displayed pixel by one clock to cover the pattern generator's register.
  always_comb begin
    act_h   = (cnt_h_q >= H_ACT_START) && (cnt_h_q <= H_ACT_END);
    act_v   = (cnt_v_q >= V_ACT_START) && (cnt_v_q <= V_ACT_END);
    req_h   = (cnt_h_q >= H_REQ_START) && (cnt_h_q <= H_REQ_END);
    pix_req = req_h && act_v;
    pix_x   = pix_req ? (cnt_h_q - H_REQ_START) : 10'h3FF;
    pix_y   = pix_req ? (cnt_v_q - V_ACT_START) : 10'h3FF;
  end

  assign hsync       = (cnt_h_q < H_SYNC_END);
  assign vsync       = (cnt_v_q < V_SYNC_END);
  assign rgb_valid   = act_h && act_v;
  assign frame_start = frame_start_q;

`ifdef VGA_BORDER_EN
  logic border;

  always_comb begin
    border = (cnt_h_q == H_ACT_START) || (cnt_h_q == H_ACT_END) ||
             (cnt_v_q == V_ACT_START) || (cnt_v_q == V_ACT_END);
    rgb    = rgb_valid ? (border ? 16'hFFFF : pix_data) : 16'h0000;
  end
`else
  assign rgb = rgb_valid ? pix_data : 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: full-size instance plus a shrunken-timing
// instance so frame wrap and frame_start can be exercised in a short run.
module tb_vga_timing_ctrl;

  localparam int HT = 800;
  localparam int VT = 525;
  localparam int SHS = 4, SHB = 3, SHV = 8, SHF = 2, SHT = 17;
  localparam int SVS = 1, SVB = 2, SVV = 4, SVF = 1, SVT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;

  logic [15:0] pix_data, rgb;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, rgb_valid, frame_start;

  logic [15:0] s_pix_data, s_rgb;
  logic [9:0]  s_pix_x, s_pix_y;
  logic        s_hsync, s_vsync, s_rgb_valid, s_frame_start;

  int total = 0;
  int bad = 0;

  int mh, mv, sh, sv;
  logic mfs, smfs;
  logic [15:0] q_big[$];
  logic [15:0] q_small[$];

  always #20 clk = ~clk;

  vga_timing_ctrl u_dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .rgb_valid(rgb_valid), .frame_start(frame_start)
  );

  vga_timing_ctrl #(
    .H_SYNC(SHS), .H_BACK(SHB), .H_VALID(SHV), .H_FRONT(SHF), .H_TOTAL(SHT),
    .V_SYNC(SVS), .V_BACK(SVB), .V_VALID(SVV), .V_FRONT(SVF), .V_TOTAL(SVT)
  ) u_small (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(s_pix_data),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .hsync(s_hsync), .vsync(s_vsync),
    .rgb(s_rgb), .rgb_valid(s_rgb_valid), .frame_start(s_frame_start)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       valid;
    logic [9:0] px;
    logic [9:0] py;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        valid;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [15:0] rgb;
  } vec_t;

  function automatic logic [15:0] pat_big(logic [9:0] x);
    logic [15:0] bars [10];
    bars = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
             16'h001F, 16'h801F, 16'hF81F, 16'hFFFF, 16'h8410};
    if (x >= 10'd640) return 16'h0000;
    return bars[int'(x) / 64];
  endfunction

  function automatic logic [15:0] pat_small(logic [9:0] x, logic [9:0] y);
    if (x == 10'h3FF) return 16'h0000;
    return {y[5:0], x};
  endfunction

  function automatic exp_t model(int h, int v, int hs_w, int hb, int hv,
                                 int vs_w, int vb, int vv);
    exp_t e;
    int hstart, vstart;
    logic rows, req;
    hstart  = hs_w + hb;
    vstart  = vs_w + vb;
    rows    = (v >= vstart) && (v < vstart + vv);
    req     = (h >= hstart - 1) && (h < hstart + hv - 1) && rows;
    e.hs    = (h < hs_w);
    e.vs    = (v < vs_w);
    e.valid = (h >= hstart) && (h < hstart + hv) && rows;
    e.px    = req ? 10'(h - (hstart - 1)) : 10'h3FF;
    e.py    = req ? 10'(v - vstart) : 10'h3FF;
    return e;
  endfunction

  function automatic logic [15:0] disp(logic valid, logic [15:0] d, int h, int v,
                                       int hstart, int hv, int vstart, int vv);
    if (!valid) return 16'h0000;
`ifdef VGA_BORDER_EN
    if (h == hstart || h == hstart + hv - 1 || v == vstart || v == vstart + vv - 1)
      return 16'hFFFF;
`endif
    return d;
  endfunction

  function automatic logic [15:0] req_big(int h, int v);
    exp_t e;
    e = model(h, v, 96, 48, 640, 2, 33, 480);
    return pat_big(e.px);
  endfunction

  function automatic logic [15:0] req_small(int h, int v);
    exp_t e;
    e = model(h, v, SHS, SHB, SHV, SVS, SVB, SVV);
    return pat_small(e.px, e.py);
  endfunction

  function automatic logic [63:0] exp_big(int h, int v, logic fs, logic [15:0] d);
    exp_t e;
    e = model(h, v, 96, 48, 640, 2, 33, 480);
    return {24'b0, e.hs, e.vs, e.valid, e.px, e.py, disp(e.valid, d, h, v, 144, 640, 35, 480), fs};
  endfunction

  function automatic logic [63:0] exp_small(int h, int v, logic fs, logic [15:0] d);
    exp_t e;
    e = model(h, v, SHS, SHB, SHV, SVS, SVB, SVV);
    return {24'b0, e.hs, e.vs, e.valid, e.px, e.py,
            disp(e.valid, d, h, v, SHS + SHB, SHV, SVS + SVB, SVV), fs};
  endfunction

  function automatic logic [15:0] pop_big();
    if (q_big.size() > 0) return q_big.pop_front();
    return 16'h0000;
  endfunction

  function automatic logic [15:0] pop_small();
    if (q_small.size() > 0) return q_small.pop_front();
    return 16'h0000;
  endfunction

  // Reference position counters; each clock also queues the pixel the generator will return.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh <= 0; mv <= 0; mfs <= 1'b0;
      sh <= 0; sv <= 0; smfs <= 1'b0;
      q_big.delete();
      q_small.delete();
    end else begin
      q_big.push_back(req_big(mh, mv));
      q_small.push_back(req_small(sh, sv));
      mfs  <= (mh == HT - 1) && (mv == VT - 1);
      mh   <= (mh == HT - 1) ? 0 : mh + 1;
      if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
      smfs <= (sh == SHT - 1) && (sv == SVT - 1);
      sh   <= (sh == SHT - 1) ? 0 : sh + 1;
      if (sh == SHT - 1) sv <= (sv == SVT - 1) ? 0 : sv + 1;
    end
  end

  // Stand-in pattern generators with the one-cycle registered latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data   <= 16'h0000;
      s_pix_data <= 16'h0000;
    end else begin
      pix_data   <= pat_big(pix_x);
      s_pix_data <= pat_small(s_pix_x, s_pix_y);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (model h=%0d v=%0d)", name, act, expv, mh, mv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cycle_big",
                  {24'b0, hsync, vsync, rgb_valid, pix_x, pix_y, rgb, frame_start},
                  exp_big(mh, mv, mfs, pop_big()));
      checkOutput("cycle_small",
                  {24'b0, s_hsync, s_vsync, s_rgb_valid, s_pix_x, s_pix_y, s_rgb, s_frame_start},
                  exp_small(sh, sv, smfs, pop_small()));
    end
  end

  task automatic applyStimulus(input int h, input int v);
    for (int n = 0; n < 100000; n++) begin
      @(negedge clk);
      if (mh == h && mv == v) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL reach_pos: got timeout expected h=%0d v=%0d", h, v);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hsync"}, 64'(hsync), 64'd1);
    checkOutput({tag, "_vsync"}, 64'(vsync), 64'd1);
    checkOutput({tag, "_valid"}, 64'(rgb_valid), 64'd0);
    checkOutput({tag, "_rgb"}, 64'(rgb), 64'd0);
    checkOutput({tag, "_pix_x"}, 64'(pix_x), 64'h3FF);
    checkOutput({tag, "_pix_y"}, 64'(pix_y), 64'h3FF);
    checkOutput({tag, "_fs"}, 64'(frame_start), 64'd0);
  endtask

  vec_t vecs[14];

  initial begin
    int hfall, hrise, vr1, vr2, fs1, fs2, fscnt, vshigh;
    logic ph, pv;
    logic [15:0] want;

    vecs[0]  = '{95,  0,  1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[1]  = '{96,  0,  1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[2]  = '{0,   1,  1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[3]  = '{0,   2,  1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[4]  = '{500, 34, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[5]  = '{142, 35, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[6]  = '{143, 35, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   16'h0000};
    vecs[7]  = '{144, 35, 1'b0, 1'b0, 1'b1, 10'd1,   10'd0,   16'hF800};
    vecs[8]  = '{207, 35, 1'b0, 1'b0, 1'b1, 10'd64,  10'd0,   16'hF800};
    vecs[9]  = '{208, 35, 1'b0, 1'b0, 1'b1, 10'd65,  10'd0,   16'hFC00};
    vecs[10] = '{782, 35, 1'b0, 1'b0, 1'b1, 10'd639, 10'd0,   16'h8410};
    vecs[11] = '{783, 35, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h8410};
    vecs[12] = '{784, 35, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
    vecs[13] = '{143, 36, 1'b0, 1'b0, 1'b0, 10'd0,   10'd1,   16'h0000};

    #1 rst_n = 1'b0;
    #1 checkResetState("reset");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #5 rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].h, vecs[i].v);
      want = vecs[i].rgb;
`ifdef VGA_BORDER_EN
      if (vecs[i].valid && (vecs[i].h == 144 || vecs[i].h == 783 || vecs[i].v == 35 || vecs[i].v == 514))
        want = 16'hFFFF;
`endif
      checkOutput($sformatf("vec%0d_sync", i), 64'({hsync, vsync}), 64'({vecs[i].hs, vecs[i].vs}));
      checkOutput($sformatf("vec%0d_valid", i), 64'(rgb_valid), 64'(vecs[i].valid));
      checkOutput($sformatf("vec%0d_pix_x", i), 64'(pix_x), 64'(vecs[i].px));
      checkOutput($sformatf("vec%0d_pix_y", i), 64'(pix_y), 64'(vecs[i].py));
      checkOutput($sformatf("vec%0d_rgb", i), 64'(rgb), 64'(want));
    end

    // Reset dropped mid-line between edges must clear outputs before the next clock.
    applyStimulus(400, 36);
    checkOutput("pre_reset_pix_x", 64'(pix_x), 64'd257);
    #5 rst_n = 1'b0;
    #1 checkResetState("midreset");
    repeat (2) @(negedge clk);
    #5 rst_n = 1'b1;

    hfall = -1; hrise = -1; vr1 = -1; vr2 = -1; fs1 = -1; fs2 = -1;
    fscnt = 0; vshigh = 0; ph = 1'b1; pv = 1'b1;
    for (int k = 1; k < 820; k++) begin
      @(negedge clk);
      if (ph && !hsync && hfall < 0) hfall = k;
      if (!ph && hsync && hrise < 0) hrise = k;
      ph = hsync;
      if (!pv && s_vsync) begin
        if (vr1 < 0) vr1 = k;
        else if (vr2 < 0) vr2 = k;
      end
      pv = s_vsync;
      if (s_frame_start) begin
        if (k <= 272) fscnt++;
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k >= 136 && k < 272 && s_vsync) vshigh++;
    end
    checkOutput("hsync_fall_clk", 64'(hfall), 64'd96);
    checkOutput("hsync_period", 64'(hrise), 64'd800);
    checkOutput("small_vsync_rise1", 64'(vr1), 64'd136);
    checkOutput("small_vsync_rise2", 64'(vr2), 64'd272);
    checkOutput("small_vsync_width", 64'(vshigh), 64'd17);
    checkOutput("small_fs_first", 64'(fs1), 64'd136);
    checkOutput("small_fs_second", 64'(fs2), 64'd272);
    checkOutput("small_fs_count", 64'(fscnt), 64'd2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
